// File: rtl/exec_pkg.sv
// Shared types and constants for the LEGv8 execute stage: ALU control,
// R-type opcodes, forwarding selects and the stage FSM state.
package exec_pkg;

    typedef enum logic [2:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_ORR,
        ALU_PASSB,
        ALU_MUL
    } alu_ctrl_e;

    localparam logic [10:0] OPC_ADD = 11'b10001011000;
    localparam logic [10:0] OPC_SUB = 11'b11001011000;
    localparam logic [10:0] OPC_AND = 11'b10001010000;
    localparam logic [10:0] OPC_ORR = 11'b10101010000;
    localparam logic [10:0] OPC_MUL = 11'b10011011000;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

    typedef enum logic {
        ST_IDLE,
        ST_MUL
    } state_e;

endpackage

// File: rtl/execute_stage_pl_iter_mul.sv
// Radix-2 shift-add multiplier: one partial product per edge while run is high,
// done is raised combinationally on the last iteration together with the product.
module iter_mul #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            run,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            done,
    output logic [XLEN-1:0] product
);

    localparam int CW = (XLEN > 1) ? $clog2(XLEN) : 1;

    logic [XLEN-1:0] acc;
    logic [XLEN-1:0] mcand;
    logic [XLEN-1:0] mplier;
    logic [CW-1:0]   cnt;

    // product already includes the current iteration's partial product
    assign product = acc + (mplier[0] ? mcand : '0);
    assign done    = run && (cnt == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
        end else if (start) begin
            acc    <= '0;
            mcand  <= a;
            mplier <= b;
            cnt    <= CW'(XLEN - 1);
        end else if (run) begin
            acc    <= product;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            if (cnt != '0)
                cnt <= cnt - 1'b1;
        end
    end

endmodule

// File: rtl/execute_stage_pl.sv
// Registered LEGv8 execute stage with MEM/WB forwarding, an iterative
// multiplier and valid/ready handshakes; owns the EX/MEM result register.
module execute_stage_pl
    import exec_pkg::*;
#(
    parameter int XLEN      = 64,
    parameter int OPC_W     = 11,
    parameter int IMM_SHIFT = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [XLEN-1:0]  rd1,
    input  logic [XLEN-1:0]  rd2,
    input  logic [XLEN-1:0]  imm,
    input  logic [XLEN-1:0]  pc,
    input  logic [OPC_W-1:0] opcode,
    input  logic [1:0]       alu_op,
    input  logic             alu_src,
    input  logic [1:0]       fwd_a_sel,
    input  logic [1:0]       fwd_b_sel,
    input  logic [XLEN-1:0]  mem_fwd_data,
    input  logic [XLEN-1:0]  wb_fwd_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  alu_result,
    output logic             zero,
    output logic [XLEN-1:0]  branch_target,
    output logic [XLEN-1:0]  store_data,
    output logic             busy
);

    state_e          state, state_nxt;
    alu_ctrl_e       ctrl;
    logic [XLEN-1:0] op_a, op_bf, op_b, alu_y, tgt;
    logic            accept, mul_start, mul_done;
    logic [XLEN-1:0] mul_prod;

    function automatic logic [XLEN-1:0] fwd(input logic [XLEN-1:0] reg_val,
                                            input logic [1:0] sel,
                                            input logic [XLEN-1:0] mem_val,
                                            input logic [XLEN-1:0] wb_val);
        case (sel)
            FWD_MEM: return mem_val;
            FWD_WB:  return wb_val;
            default: return reg_val;
        endcase
    endfunction

    always_comb begin
        op_a  = fwd(rd1, fwd_a_sel, mem_fwd_data, wb_fwd_data);
        op_bf = fwd(rd2, fwd_b_sel, mem_fwd_data, wb_fwd_data);
        op_b  = alu_src ? imm : op_bf;
        tgt   = pc + (imm << IMM_SHIFT);
    end

    // Unknown R-type opcodes fall back to ADD rather than trapping
    always_comb begin
        ctrl = ALU_ADD;
        case (alu_op)
            2'b01: ctrl = ALU_PASSB;
            2'b10: begin
                if      (opcode == OPC_W'(OPC_SUB)) ctrl = ALU_SUB;
                else if (opcode == OPC_W'(OPC_AND)) ctrl = ALU_AND;
                else if (opcode == OPC_W'(OPC_ORR)) ctrl = ALU_ORR;
                else if (opcode == OPC_W'(OPC_MUL)) ctrl = ALU_MUL;
                else                                ctrl = ALU_ADD;
            end
            default: ctrl = ALU_ADD;
        endcase
    end

    always_comb begin
        alu_y = op_a + op_b;
        case (ctrl)
            ALU_SUB:   alu_y = op_a - op_b;
            ALU_AND:   alu_y = op_a & op_b;
            ALU_ORR:   alu_y = op_a | op_b;
            ALU_PASSB: alu_y = op_b;
            default:   alu_y = op_a + op_b;
        endcase
    end

    assign accept    = in_valid && in_ready;
    assign mul_start = accept && (ctrl == ALU_MUL);

    iter_mul #(.XLEN(XLEN)) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (mul_start),
        .run     (state == ST_MUL),
        .a       (op_a),
        .b       (op_b),
        .done    (mul_done),
        .product (mul_prod)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (mul_start)           state_nxt = ST_MUL;
            ST_MUL:  if (flush || mul_done)   state_nxt = ST_IDLE;
            default:                          state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready = (state == ST_IDLE) && (!out_valid || out_ready) && !flush;
        busy     = (state == ST_MUL);
    end

    // Flush only drops validity; data registers keep their stale contents
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid     <= 1'b0;
            alu_result    <= '0;
            zero          <= 1'b0;
            branch_target <= '0;
            store_data    <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (mul_start) begin
            out_valid     <= 1'b0;
            branch_target <= tgt;
            store_data    <= op_bf;
        end else if (accept) begin
            out_valid     <= 1'b1;
            alu_result    <= alu_y;
            zero          <= (alu_y == '0);
            branch_target <= tgt;
            store_data    <= op_bf;
        end else if (mul_done) begin
            out_valid  <= 1'b1;
            alu_result <= mul_prod;
            zero       <= (mul_prod == '0);
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_execute_stage_pl.sv
// Scoreboard bench for execute_stage_pl: expectations are queued at issue time
// and popped when the stage presents a result.
module tb_execute_stage_pl;

    localparam logic [10:0] C_ADD = 11'b10001011000;
    localparam logic [10:0] C_SUB = 11'b11001011000;
    localparam logic [10:0] C_AND = 11'b10001010000;
    localparam logic [10:0] C_ORR = 11'b10101010000;
    localparam logic [10:0] C_MUL = 11'b10011011000;

    logic        clk, rst_n, flush, in_valid, in_ready, alu_src, out_valid, out_ready, zero, busy;
    logic [63:0] rd1, rd2, imm, pc, mem_fwd_data, wb_fwd_data, alu_result, branch_target, store_data;
    logic [10:0] opcode;
    logic [1:0]  alu_op, fwd_a_sel, fwd_b_sel;

    typedef struct {
        logic [63:0] res;
        logic        z;
        logic [63:0] bt;
        logic [63:0] sd;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   n_checks = 0;
    int   n_pass   = 0;

    execute_stage_pl dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .rd1(rd1), .rd2(rd2), .imm(imm), .pc(pc), .opcode(opcode), .alu_op(alu_op),
        .alu_src(alu_src), .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
        .mem_fwd_data(mem_fwd_data), .wb_fwd_data(wb_fwd_data), .out_valid(out_valid),
        .out_ready(out_ready), .alu_result(alu_result), .zero(zero),
        .branch_target(branch_target), .store_data(store_data), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic exp_t predict(input logic [1:0] aop, input logic [10:0] opc,
                                     input logic [63:0] a_reg, input logic [63:0] b_reg,
                                     input logic [63:0] im, input logic [63:0] p, input logic src,
                                     input logic [1:0] fa, input logic [1:0] fb,
                                     input logic [63:0] mv, input logic [63:0] wv);
        exp_t        r;
        logic [63:0] a, bf, b;
        a  = (fa == 2'b01) ? mv : (fa == 2'b10) ? wv : a_reg;
        bf = (fb == 2'b01) ? mv : (fb == 2'b10) ? wv : b_reg;
        b  = src ? im : bf;
        r.res = a + b;
        if (aop == 2'b01) r.res = b;
        else if (aop == 2'b10) begin
            if      (opc == C_SUB) r.res = a - b;
            else if (opc == C_AND) r.res = a & b;
            else if (opc == C_ORR) r.res = a | b;
            else if (opc == C_MUL) r.res = a * b;
        end
        r.z  = (r.res == 64'd0);
        r.bt = p + (im << 2);
        r.sd = bf;
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [1:0] aop, input logic [10:0] opc, input logic [63:0] a_reg,
                         input logic [63:0] b_reg, input logic [63:0] im, input logic [63:0] p,
                         input logic src, input logic [1:0] fa, input logic [1:0] fb,
                         input logic [63:0] mv, input logic [63:0] wv);
        alu_op = aop; opcode = opc; rd1 = a_reg; rd2 = b_reg; imm = im; pc = p;
        alu_src = src; fwd_a_sel = fa; fwd_b_sel = fb; mem_fwd_data = mv; wb_fwd_data = wv;
        in_valid = 1'b1;
        sb.push_back(predict(aop, opc, a_reg, b_reg, im, p, src, fa, fb, mv, wv));
    endtask

    task automatic test_reset();
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        alu_op = 2'b00; opcode = '0; rd1 = '0; rd2 = '0; imm = '0; pc = '0; alu_src = 1'b0;
        fwd_a_sel = 2'b00; fwd_b_sel = 2'b00; mem_fwd_data = '0; wb_fwd_data = '0;
        #13;
        n_checks++; if (out_valid !== 1'b0) $display("[TB] FAIL reset_valid: got %b expected 0", out_valid); else n_pass++;
        n_checks++; if (alu_result !== 64'd0) $display("[TB] FAIL reset_result: got %h expected 0", alu_result); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("[TB] FAIL reset_busy: got %b expected 0", busy); else n_pass++;
        n_checks++; if (in_ready !== 1'b1) $display("[TB] FAIL reset_ready: got %b expected 1", in_ready); else n_pass++;
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_add();
        issue(2'b10, C_ADD, 64'd5, 64'd7, 64'd3, 64'h100, 1'b0, 2'b00, 2'b00, '0, '0);
        step();
        in_valid = 1'b0;
        n_checks++; if (out_valid !== 1'b1) $display("[TB] FAIL add_valid: got %b expected 1", out_valid); else n_pass++;
        e = sb.pop_front();
        n_checks++; if (alu_result !== e.res) $display("[TB] FAIL add_result: got %h expected %h", alu_result, e.res); else n_pass++;
        n_checks++; if (zero !== e.z) $display("[TB] FAIL add_zero: got %b expected %b", zero, e.z); else n_pass++;
        n_checks++; if (branch_target !== e.bt) $display("[TB] FAIL add_target: got %h expected %h", branch_target, e.bt); else n_pass++;
        n_checks++; if (store_data !== e.sd) $display("[TB] FAIL add_store: got %h expected %h", store_data, e.sd); else n_pass++;
        step();
        n_checks++; if (out_valid !== 1'b0) $display("[TB] FAIL add_drain: got %b expected 0", out_valid); else n_pass++;
    endtask

    task automatic test_back_to_back();
        issue(2'b10, C_SUB, 64'd9, 64'd9, 64'd0, 64'h200, 1'b0, 2'b00, 2'b01, 64'd4, 64'd0);
        step();
        e = sb.pop_front();
        n_checks++; if (alu_result !== e.res) $display("[TB] FAIL fwd_mem_result: got %h expected %h", alu_result, e.res); else n_pass++;
        issue(2'b10, C_SUB, 64'd9, 64'd9, 64'd0, 64'h204, 1'b0, 2'b10, 2'b01, 64'd4, 64'd4);
        step();
        issue(2'b10, C_ORR, 64'hF0, 64'h0F, 64'd0, 64'h208, 1'b0, 2'b00, 2'b00, '0, '0);
        e = sb.pop_front();
        n_checks++; if (out_valid !== 1'b1) $display("[TB] FAIL b2b_valid: got %b expected 1", out_valid); else n_pass++;
        n_checks++; if (alu_result !== e.res) $display("[TB] FAIL fwd_wb_result: got %h expected %h", alu_result, e.res); else n_pass++;
        n_checks++; if (zero !== e.z) $display("[TB] FAIL fwd_wb_zero: got %b expected %b", zero, e.z); else n_pass++;
        step();
        issue(2'b01, C_AND, 64'd1, 64'd2, 64'h55, 64'h20C, 1'b1, 2'b00, 2'b00, '0, '0);
        e = sb.pop_front();
        n_checks++; if (alu_result !== e.res) $display("[TB] FAIL orr_result: got %h expected %h", alu_result, e.res); else n_pass++;
        step();
        in_valid = 1'b0;
        e = sb.pop_front();
        n_checks++; if (alu_result !== e.res) $display("[TB] FAIL passb_result: got %h expected %h", alu_result, e.res); else n_pass++;
        n_checks++; if (store_data !== e.sd) $display("[TB] FAIL passb_store: got %h expected %h", store_data, e.sd); else n_pass++;
        step();
    endtask

    task automatic test_mul();
        int  cyc;
        bit  leak;
        issue(2'b10, C_MUL, 64'hFFFF_FFFF_FFFF_FFFF, 64'd3, 64'd1, 64'h300, 1'b0, 2'b00, 2'b00, '0, '0);
        step();
        in_valid = 1'b0;
        n_checks++; if (busy !== 1'b1) $display("[TB] FAIL mul_busy: got %b expected 1", busy); else n_pass++;
        cyc  = 0;
        leak = 1'b0;
        while (!out_valid && cyc < 100) begin
            if (in_ready) leak = 1'b1;
            step();
            cyc++;
        end
        n_checks++; if (cyc !== 64) $display("[TB] FAIL mul_latency: got %0d expected 64", cyc); else n_pass++;
        n_checks++; if (leak !== 1'b0) $display("[TB] FAIL mul_ready: got %b expected 0", leak); else n_pass++;
        e = sb.pop_front();
        n_checks++; if (alu_result !== e.res) $display("[TB] FAIL mul_result: got %h expected %h", alu_result, e.res); else n_pass++;
        n_checks++; if (branch_target !== e.bt) $display("[TB] FAIL mul_target: got %h expected %h", branch_target, e.bt); else n_pass++;
        n_checks++; if (store_data !== e.sd) $display("[TB] FAIL mul_store: got %h expected %h", store_data, e.sd); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("[TB] FAIL mul_idle: got %b expected 0", busy); else n_pass++;
        step();
    endtask

    task automatic test_hold();
        out_ready = 1'b0;
        issue(2'b10, C_ADD, 64'd2, 64'd3, 64'd0, 64'h400, 1'b0, 2'b00, 2'b00, '0, '0);
        step();
        issue(2'b10, C_ADD, 64'd10, 64'd20, 64'd0, 64'h404, 1'b0, 2'b00, 2'b00, '0, '0);
        for (int i = 0; i < 5; i++) begin
            n_checks++; if (in_ready !== 1'b0) $display("[TB] FAIL hold_ready%0d: got %b expected 0", i, in_ready); else n_pass++;
            n_checks++; if (alu_result !== sb[0].res) $display("[TB] FAIL hold_result%0d: got %h expected %h", i, alu_result, sb[0].res); else n_pass++;
            step();
        end
        e = sb.pop_front();
        n_checks++; if (out_valid !== 1'b1) $display("[TB] FAIL hold_valid: got %b expected 1", out_valid); else n_pass++;
        n_checks++; if (branch_target !== e.bt) $display("[TB] FAIL hold_target: got %h expected %h", branch_target, e.bt); else n_pass++;
        out_ready = 1'b1;
        #1;
        n_checks++; if (in_ready !== 1'b1) $display("[TB] FAIL release_ready: got %b expected 1", in_ready); else n_pass++;
        step();
        in_valid = 1'b0;
        e = sb.pop_front();
        n_checks++; if (alu_result !== e.res) $display("[TB] FAIL release_result: got %h expected %h", alu_result, e.res); else n_pass++;
    endtask

    task automatic test_flush();
        issue(2'b10, C_MUL, 64'd7, 64'd9, 64'd0, 64'h500, 1'b0, 2'b00, 2'b00, '0, '0);
        step();
        in_valid = 1'b0;
        repeat (19) step();
        void'(sb.pop_back());
        flush = 1'b1;
        alu_op = 2'b00;
        in_valid = 1'b1;
        #1;
        n_checks++; if (in_ready !== 1'b0) $display("[TB] FAIL flush_ready: got %b expected 0", in_ready); else n_pass++;
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        n_checks++; if (busy !== 1'b0) $display("[TB] FAIL flush_busy: got %b expected 0", busy); else n_pass++;
        n_checks++; if (out_valid !== 1'b0) $display("[TB] FAIL flush_valid: got %b expected 0", out_valid); else n_pass++;
        issue(2'b00, C_SUB, 64'd1, 64'd1, 64'd0, 64'h600, 1'b0, 2'b00, 2'b00, '0, '0);
        step();
        in_valid = 1'b0;
        e = sb.pop_front();
        n_checks++; if (out_valid !== 1'b1) $display("[TB] FAIL post_flush_valid: got %b expected 1", out_valid); else n_pass++;
        n_checks++; if (alu_result !== e.res) $display("[TB] FAIL post_flush_result: got %h expected %h", alu_result, e.res); else n_pass++;
        step();
    endtask

    task automatic test_async_reset();
        issue(2'b10, C_MUL, 64'd5, 64'd6, 64'd2, 64'h700, 1'b0, 2'b00, 2'b00, '0, '0);
        step();
        in_valid = 1'b0;
        repeat (10) step();
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++; if (busy !== 1'b0) $display("[TB] FAIL areset_busy: got %b expected 0", busy); else n_pass++;
        n_checks++; if (alu_result !== 64'd0) $display("[TB] FAIL areset_result: got %h expected 0", alu_result); else n_pass++;
        n_checks++; if (branch_target !== 64'd0) $display("[TB] FAIL areset_target: got %h expected 0", branch_target); else n_pass++;
        n_checks++; if (store_data !== 64'd0) $display("[TB] FAIL areset_store: got %h expected 0", store_data); else n_pass++;
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        step();
        n_checks++; if (in_ready !== 1'b1) $display("[TB] FAIL areset_ready: got %b expected 1", in_ready); else n_pass++;
        n_checks++; if (out_valid !== 1'b0) $display("[TB] FAIL areset_valid: got %b expected 0", out_valid); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_add();
        test_back_to_back();
        test_mul();
        test_hold();
        test_flush();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
